// File: rtl/pipe_ctrl_pkg.sv
// Shared types for the pipelined RV32I control unit: opcodes, ALU codes,
// immediate/result selects and the per-stage control bundles.
package pipe_ctrl_pkg;

    typedef enum logic [6:0] {
        OPC_LOAD   = 7'b0000011,
        OPC_STORE  = 7'b0100011,
        OPC_OP     = 7'b0110011,
        OPC_OP_IMM = 7'b0010011,
        OPC_BRANCH = 7'b1100011,
        OPC_JAL    = 7'b1101111,
        OPC_JALR   = 7'b1100111,
        OPC_LUI    = 7'b0110111,
        OPC_AUIPC  = 7'b0010111
    } opcode_t;

    typedef enum logic [3:0] {
        ALU_ADD   = 4'b0000,
        ALU_SUB   = 4'b0001,
        ALU_AND   = 4'b0010,
        ALU_OR    = 4'b0011,
        ALU_XOR   = 4'b0100,
        ALU_SLT   = 4'b0101,
        ALU_SLTU  = 4'b0110,
        ALU_SLL   = 4'b0111,
        ALU_SRL   = 4'b1000,
        ALU_SRA   = 4'b1001,
        ALU_PASSB = 4'b1010
    } alu_op_t;

    typedef enum logic [2:0] {
        IMM_I = 3'b000,
        IMM_S = 3'b001,
        IMM_B = 3'b010,
        IMM_J = 3'b011,
        IMM_U = 3'b100
    } imm_src_t;

    typedef enum logic [1:0] {
        RES_ALU = 2'b00,
        RES_MEM = 2'b01,
        RES_PC4 = 2'b10
    } result_src_t;

    typedef struct packed {
        alu_op_t     alu_ctrl;
        logic        alu_src_b;
        logic        alu_src_a_pc;
        logic        branch;
        logic        jump;
        logic        jalr;
        logic        valid;
        logic        mem_read;
        logic        mem_write;
        logic        reg_write;
        result_src_t result_src;
        logic [2:0]  funct3;
        logic [4:0]  rd;
    } ctrl_bundle_t;

    // Later stages only carry what they still consume.
    typedef struct packed {
        logic        mem_read;
        logic        mem_write;
        logic [2:0]  funct3;
        logic        reg_write;
        result_src_t result_src;
        logic [4:0]  rd;
    } mem_bundle_t;

    typedef struct packed {
        logic        reg_write;
        result_src_t result_src;
        logic [4:0]  rd;
    } wb_bundle_t;

    localparam ctrl_bundle_t BUBBLE = '0;

    function automatic alu_op_t arith_op(input logic [2:0] f3, input logic alt,
                                         input logic is_reg, input logic en_shift);
        alu_op_t op;
        case (f3)
            3'b000:  op = (is_reg && alt) ? ALU_SUB : ALU_ADD;
            3'b001:  op = en_shift ? ALU_SLL : ALU_ADD;
            3'b010:  op = ALU_SLT;
            3'b011:  op = ALU_SLTU;
            3'b100:  op = ALU_XOR;
            3'b101:  op = en_shift ? (alt ? ALU_SRA : ALU_SRL) : ALU_ADD;
            3'b110:  op = ALU_OR;
            default: op = ALU_AND;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/pipe_ctrl_unit_decode.sv
// Combinational RV32I decoder: control bundle, immediate format and the
// source registers actually read (zeroed when the format has none).
module ctrl_decode
    import pipe_ctrl_pkg::*;
#(
    parameter bit EN_SHIFT = 1'b1
) (
    input  logic [31:0]  instr_i,
    output ctrl_bundle_t ctrl_o,
    output imm_src_t     imm_src_o,
    output logic         illegal_o,
    output logic [4:0]   rs1_o,
    output logic [4:0]   rs2_o
);

    logic [2:0] f3;
    logic       legal;
    logic       use_rs1;
    logic       use_rs2;
    logic       unused_bits;

    assign f3          = instr_i[14:12];
    assign unused_bits = ^{instr_i[31], instr_i[29:25]};

    always_comb begin
        ctrl_o    = BUBBLE;
        imm_src_o = IMM_I;
        illegal_o = 1'b0;
        legal     = 1'b1;
        use_rs1   = 1'b1;
        use_rs2   = 1'b0;
        case (instr_i[6:0])
            OPC_LOAD: begin
                ctrl_o.alu_src_b  = 1'b1;
                ctrl_o.mem_read   = 1'b1;
                ctrl_o.reg_write  = 1'b1;
                ctrl_o.result_src = RES_MEM;
            end
            OPC_STORE: begin
                ctrl_o.alu_src_b = 1'b1;
                ctrl_o.mem_write = 1'b1;
                imm_src_o        = IMM_S;
                use_rs2          = 1'b1;
            end
            OPC_OP: begin
                ctrl_o.alu_ctrl  = arith_op(f3, instr_i[30], 1'b1, EN_SHIFT);
                ctrl_o.reg_write = 1'b1;
                use_rs2          = 1'b1;
            end
            OPC_OP_IMM: begin
                ctrl_o.alu_ctrl  = arith_op(f3, instr_i[30], 1'b0, EN_SHIFT);
                ctrl_o.alu_src_b = 1'b1;
                ctrl_o.reg_write = 1'b1;
            end
            OPC_BRANCH: begin
                ctrl_o.alu_ctrl = !f3[2] ? ALU_SUB : (f3[1] ? ALU_SLTU : ALU_SLT);
                ctrl_o.branch   = 1'b1;
                imm_src_o       = IMM_B;
                use_rs2         = 1'b1;
            end
            OPC_JAL: begin
                ctrl_o.jump       = 1'b1;
                ctrl_o.reg_write  = 1'b1;
                ctrl_o.result_src = RES_PC4;
                imm_src_o         = IMM_J;
                use_rs1           = 1'b0;
            end
            OPC_JALR: begin
                ctrl_o.alu_src_b  = 1'b1;
                ctrl_o.jalr       = 1'b1;
                ctrl_o.reg_write  = 1'b1;
                ctrl_o.result_src = RES_PC4;
            end
            OPC_LUI: begin
                ctrl_o.alu_ctrl  = ALU_PASSB;
                ctrl_o.alu_src_b = 1'b1;
                ctrl_o.reg_write = 1'b1;
                imm_src_o        = IMM_U;
                use_rs1          = 1'b0;
            end
            OPC_AUIPC: begin
                ctrl_o.alu_src_b    = 1'b1;
                ctrl_o.alu_src_a_pc = 1'b1;
                ctrl_o.reg_write    = 1'b1;
                imm_src_o           = IMM_U;
                use_rs1             = 1'b0;
            end
            default: begin
                legal     = 1'b0;
                use_rs1   = 1'b0;
                illegal_o = 1'b1;
            end
        endcase
        if (legal) begin
            ctrl_o.valid  = 1'b1;
            ctrl_o.funct3 = f3;
            // rd stays 0 for non-writing formats so the hazard check never sees it.
            if (ctrl_o.reg_write) begin
                ctrl_o.rd = instr_i[11:7];
                if (instr_i[11:7] == 5'd0) ctrl_o.reg_write = 1'b0;
            end
        end
    end

    assign rs1_o = use_rs1 ? instr_i[19:15] : 5'd0;
    assign rs2_o = use_rs2 ? instr_i[24:20] : 5'd0;

endmodule

// File: rtl/pipe_ctrl_unit.sv
// Pipelined control unit: decodes in ID, carries control through ID/EX,
// EX/MEM and MEM/WB, with load-use stall and EX-redirect flush bubbles.
module pipe_ctrl_unit
    import pipe_ctrl_pkg::*;
#(
    parameter int ALUCTRL_W = 4,
    parameter int RADDR_W   = 5,
    parameter int EN_SHIFT  = 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [31:0]            id_instr,
    input  logic                   id_valid,
    input  logic                   ex_redirect,
    output logic [2:0]             id_imm_src,
    output logic                   id_stall,
    output logic [ALUCTRL_W+5:0]   ex_ctrl,
    output logic [2:0]             ex_funct3,
    output logic                   mem_write,
    output logic                   mem_read,
    output logic [2:0]             mem_funct3,
    output logic                   wb_reg_write,
    output logic [1:0]             wb_result_src,
    output logic [RADDR_W-1:0]     wb_rd,
    output logic                   illegal
);

    ctrl_bundle_t dec_ctrl;
    imm_src_t     dec_imm_src;
    logic         dec_illegal;
    logic [4:0]   dec_rs1;
    logic [4:0]   dec_rs2;

    ctrl_decode #(.EN_SHIFT(EN_SHIFT != 0)) u_dec (
        .instr_i   (id_instr),
        .ctrl_o    (dec_ctrl),
        .imm_src_o (dec_imm_src),
        .illegal_o (dec_illegal),
        .rs1_o     (dec_rs1),
        .rs2_o     (dec_rs2)
    );

    ctrl_bundle_t ex_q, ex_d;
    mem_bundle_t  mem_q, mem_d;
    wb_bundle_t   wb_q, wb_d;
    logic         illegal_q, illegal_d;
    logic         load_use;
    logic         issue;

    // Unused source registers decode as x0, and a load rd is never x0 here.
    assign load_use = ex_q.valid && ex_q.mem_read && (ex_q.rd != 5'd0) && id_valid &&
                      ((dec_rs1 == ex_q.rd) || (dec_rs2 == ex_q.rd));
    assign id_stall = load_use && !ex_redirect;
    assign issue    = id_valid && !ex_redirect && !load_use;

    always_comb begin
        ex_d      = issue ? dec_ctrl : BUBBLE;
        illegal_d = issue && dec_illegal;

        mem_d            = '0;
        mem_d.mem_read   = ex_q.mem_read;
        mem_d.mem_write  = ex_q.mem_write;
        mem_d.funct3     = ex_q.funct3;
        mem_d.reg_write  = ex_q.reg_write;
        mem_d.result_src = ex_q.result_src;
        mem_d.rd         = ex_q.rd;

        wb_d            = '0;
        wb_d.reg_write  = mem_q.reg_write;
        wb_d.result_src = mem_q.result_src;
        wb_d.rd         = mem_q.rd;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_q      <= BUBBLE;
            mem_q     <= '0;
            wb_q      <= '0;
            illegal_q <= 1'b0;
        end else begin
            ex_q      <= ex_d;
            mem_q     <= mem_d;
            wb_q      <= wb_d;
            illegal_q <= illegal_d;
        end
    end

    assign id_imm_src    = dec_imm_src;
    assign ex_ctrl       = {ALUCTRL_W'(ex_q.alu_ctrl), ex_q.alu_src_b, ex_q.alu_src_a_pc,
                            ex_q.branch, ex_q.jump, ex_q.jalr, ex_q.valid};
    assign ex_funct3     = ex_q.funct3;
    assign mem_write     = mem_q.mem_write;
    assign mem_read      = mem_q.mem_read;
    assign mem_funct3    = mem_q.funct3;
    assign wb_reg_write  = wb_q.reg_write;
    assign wb_result_src = wb_q.result_src;
    assign wb_rd         = RADDR_W'(wb_q.rd);
    assign illegal       = illegal_q;

endmodule

// File: tb/tb_pipe_ctrl_unit.sv
// Directed bench for pipe_ctrl_unit: per-instruction vector table plus
// hand-written load-use, redirect and reset sequences.
module tb_pipe_ctrl_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] id_instr = '0;
    logic        id_valid = 1'b0;
    logic        ex_redirect = 1'b0;

    logic [2:0]  id_imm_src, n_id_imm_src;
    logic        id_stall, n_id_stall;
    logic [9:0]  ex_ctrl, n_ex_ctrl;
    logic [2:0]  ex_funct3, n_ex_funct3;
    logic        mem_write, n_mem_write, mem_read, n_mem_read;
    logic [2:0]  mem_funct3, n_mem_funct3;
    logic        wb_reg_write, n_wb_reg_write;
    logic [1:0]  wb_result_src, n_wb_result_src;
    logic [4:0]  wb_rd, n_wb_rd;
    logic        illegal, n_illegal;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pipe_ctrl_unit #(.ALUCTRL_W(4), .RADDR_W(5), .EN_SHIFT(1)) dut (
        .clk(clk), .rst_n(rst_n), .id_instr(id_instr), .id_valid(id_valid),
        .ex_redirect(ex_redirect), .id_imm_src(id_imm_src), .id_stall(id_stall),
        .ex_ctrl(ex_ctrl), .ex_funct3(ex_funct3), .mem_write(mem_write),
        .mem_read(mem_read), .mem_funct3(mem_funct3), .wb_reg_write(wb_reg_write),
        .wb_result_src(wb_result_src), .wb_rd(wb_rd), .illegal(illegal)
    );

    pipe_ctrl_unit #(.ALUCTRL_W(4), .RADDR_W(5), .EN_SHIFT(0)) dut_ns (
        .clk(clk), .rst_n(rst_n), .id_instr(id_instr), .id_valid(id_valid),
        .ex_redirect(ex_redirect), .id_imm_src(n_id_imm_src), .id_stall(n_id_stall),
        .ex_ctrl(n_ex_ctrl), .ex_funct3(n_ex_funct3), .mem_write(n_mem_write),
        .mem_read(n_mem_read), .mem_funct3(n_mem_funct3), .wb_reg_write(n_wb_reg_write),
        .wb_result_src(n_wb_result_src), .wb_rd(n_wb_rd), .illegal(n_illegal)
    );

    typedef struct {
        logic [31:0] instr;
        logic        valid;
        logic        redir;
        logic [9:0]  ex;
        logic [9:0]  ex_ns;
        logic [2:0]  f3;
        logic [2:0]  imm;
        logic        ill;
        logic        mrd;
        logic        mwr;
        logic        rw;
        logic [1:0]  rs;
        logic [4:0]  rd;
    } vec_t;

    localparam int NV = 18;
    vec_t vecs[NV];

    function automatic vec_t mk(input logic [31:0] instr, input logic v, input logic r,
                                input logic [9:0] ex, input logic [9:0] ex_ns,
                                input logic [2:0] f3, input logic [2:0] imm, input logic ill,
                                input logic mrd, input logic mwr, input logic rw,
                                input logic [1:0] rs, input logic [4:0] rd);
        vec_t t;
        t.instr = instr; t.valid = v; t.redir = r; t.ex = ex; t.ex_ns = ex_ns;
        t.f3 = f3; t.imm = imm; t.ill = ill; t.mrd = mrd; t.mwr = mwr;
        t.rw = rw; t.rs = rs; t.rd = rd;
        return t;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic seen6;
        //            instr         v  r  ex      ex_ns   f3 imm ill mrd mwr rw rs rd
        vecs[0]  = mk(32'h402081B3, 1, 0, 10'h041, 10'h041, 0, 0, 0, 0, 0, 1, 0, 3); // SUB x3,x1,x2
        vecs[1]  = mk(32'hFFF08193, 1, 0, 10'h021, 10'h021, 0, 0, 0, 0, 0, 1, 0, 3); // ADDI x3,x1,-1
        vecs[2]  = mk(32'h123453B7, 1, 0, 10'h2A1, 10'h2A1, 5, 4, 0, 0, 0, 1, 0, 7); // LUI x7
        vecs[3]  = mk(32'h00001217, 1, 0, 10'h031, 10'h031, 1, 4, 0, 0, 0, 1, 0, 4); // AUIPC x4
        vecs[4]  = mk(32'h000100E7, 1, 0, 10'h023, 10'h023, 0, 0, 0, 0, 0, 1, 2, 1); // JALR x1,0(x2)
        vecs[5]  = mk(32'h008000EF, 1, 0, 10'h005, 10'h005, 0, 3, 0, 0, 0, 1, 2, 1); // JAL x1,8
        vecs[6]  = mk(32'h0000A283, 1, 0, 10'h021, 10'h021, 2, 0, 0, 1, 0, 1, 1, 5); // LW x5,0(x1)
        vecs[7]  = mk(32'h0020A223, 1, 0, 10'h021, 10'h021, 2, 1, 0, 0, 1, 0, 0, 0); // SW x2,4(x1)
        vecs[8]  = mk(32'h0020E063, 1, 0, 10'h189, 10'h189, 6, 2, 0, 0, 0, 0, 0, 0); // BLTU
        vecs[9]  = mk(32'h00209063, 1, 0, 10'h049, 10'h049, 1, 2, 0, 0, 0, 0, 0, 0); // BNE
        vecs[10] = mk(32'h4020D193, 1, 0, 10'h261, 10'h021, 5, 0, 0, 0, 0, 1, 0, 3); // SRAI x3,x1,2
        vecs[11] = mk(32'h002091B3, 1, 0, 10'h1C1, 10'h001, 1, 0, 0, 0, 0, 1, 0, 3); // SLL x3,x1,x2
        vecs[12] = mk(32'h0020E1B3, 1, 0, 10'h0C1, 10'h0C1, 6, 0, 0, 0, 0, 1, 0, 3); // OR x3,x1,x2
        vecs[13] = mk(32'h00208033, 1, 0, 10'h001, 10'h001, 0, 0, 0, 0, 0, 0, 0, 0); // ADD x0
        vecs[14] = mk(32'h0000007F, 1, 0, 10'h000, 10'h000, 0, 0, 1, 0, 0, 0, 0, 0); // illegal
        vecs[15] = mk(32'h0000007F, 0, 0, 10'h000, 10'h000, 0, 0, 0, 0, 0, 0, 0, 0); // illegal, !valid
        vecs[16] = mk(32'h402081B3, 0, 0, 10'h000, 10'h000, 0, 0, 0, 0, 0, 0, 0, 0); // SUB, !valid
        vecs[17] = mk(32'h402081B3, 1, 1, 10'h000, 10'h000, 0, 0, 0, 0, 0, 0, 0, 0); // SUB, redirect

        #12;
        chk("reset ex_ctrl", ex_ctrl, 0);
        chk("reset outs", {ex_funct3, mem_write, mem_read, mem_funct3, wb_reg_write,
                           wb_result_src, wb_rd, illegal, id_stall}, 0);
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < NV; i++) begin
            id_instr = vecs[i].instr; id_valid = vecs[i].valid; ex_redirect = vecs[i].redir;
            #1;
            chk($sformatf("v%0d id_imm_src", i), id_imm_src, vecs[i].imm);
            chk($sformatf("v%0d id_stall", i), id_stall, 0);
            tick();
            chk($sformatf("v%0d ex_ctrl", i), ex_ctrl, vecs[i].ex);
            chk($sformatf("v%0d ex_ctrl noshift", i), n_ex_ctrl, vecs[i].ex_ns);
            chk($sformatf("v%0d ex_funct3", i), ex_funct3, vecs[i].f3);
            chk($sformatf("v%0d illegal", i), illegal, vecs[i].ill);
            id_valid = 1'b0; ex_redirect = 1'b0;
            tick();
            chk($sformatf("v%0d mem", i), {mem_read, mem_write, mem_funct3},
                {vecs[i].mrd, vecs[i].mwr, vecs[i].f3});
            chk($sformatf("v%0d illegal drop", i), illegal, 0);
            tick();
            chk($sformatf("v%0d wb", i), {wb_reg_write, wb_result_src, wb_rd},
                {vecs[i].rw, vecs[i].rs, vecs[i].rd});
        end

        // Load-use: LW x5 then ADD x6,x5,x2 -> one stall cycle, one bubble.
        id_instr = 32'h0000A283; id_valid = 1'b1;
        tick();
        id_instr = 32'h00228333;
        #1;
        chk("lu stall", id_stall, 1);
        tick();
        chk("lu bubble valid", ex_ctrl[0], 0);
        chk("lu load in mem", mem_read, 1);
        chk("lu stall released", id_stall, 0);
        tick();
        chk("lu add in ex", ex_ctrl, 10'h001);
        chk("lu load wb", {wb_reg_write, wb_result_src, wb_rd}, {1'b1, 2'b01, 5'd5});
        id_valid = 1'b0;
        tick(); tick(); tick();

        // Same pair with load rd=x0 -> no stall, no bubble.
        id_instr = 32'h0000A003; id_valid = 1'b1;
        tick();
        id_instr = 32'h00200333;
        #1;
        chk("x0 no stall", id_stall, 0);
        tick();
        chk("x0 add in ex", ex_ctrl, 10'h001);
        id_valid = 1'b0;
        tick(); tick(); tick();

        // Redirect overrides a pending load-use stall and kills the ID instruction.
        id_instr = 32'h0000A283; id_valid = 1'b1;
        tick();
        id_instr = 32'h00228333; ex_redirect = 1'b1;
        #1;
        chk("redir stall forced 0", id_stall, 0);
        tick();
        chk("redir ex bubble", ex_ctrl, 0);
        ex_redirect = 1'b0; id_valid = 1'b0;
        seen6 = 1'b0;
        for (int k = 0; k < 4; k++) begin
            if (wb_reg_write && wb_rd == 5'd6) seen6 = 1'b1;
            tick();
        end
        chk("redir killed never in wb", seen6, 0);

        // Asynchronous reset mid-stream, then refill latency.
        id_instr = 32'h402081B3; id_valid = 1'b1;
        tick(); tick();
        chk("pre-reset ex", ex_ctrl, 10'h041);
        #2 rst_n = 1'b0;
        #1;
        chk("async reset ex_ctrl", ex_ctrl, 0);
        chk("async reset outs", {ex_funct3, mem_write, mem_read, mem_funct3, wb_reg_write,
                                 wb_result_src, wb_rd, illegal, id_stall}, 0);
        rst_n = 1'b1;
        tick();
        id_valid = 1'b0;
        chk("refill ex", ex_ctrl, 10'h041);
        chk("refill wb c1", wb_reg_write, 0);
        tick();
        chk("refill wb c2", wb_reg_write, 0);
        tick();
        chk("refill wb c3", {wb_reg_write, wb_rd}, {1'b1, 5'd3});

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
